// File: rtl/score_display_pkg.sv
// score_display_pkg
//   Shared definitions for the two-digit score display path:
//     state_t      converter FSM states (IDLE/SHIFT/DONE)
//     SEG_DIGIT    active-high 7-segment codes for 0..9 (bit0=a .. bit6=g)
//     SEG_DASH     "-" code shown when the value cannot be displayed
//     MAX_DISPLAY  largest value that fits in two decimal digits
//     seg_decode() digit -> segment code helper
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam int unsigned MAX_DISPLAY = 99;

  // Non-decimal nibbles never reach the display in normal use; show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d <= 4'd9) return SEG_DIGIT[d];
    return SEG_DASH;
  endfunction

endpackage

// File: rtl/score_display_driver_bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter: BW-bit binary -> tens/ones BCD.
//   One conversion takes BW SHIFT edges plus one DONE edge.
//   Ports:
//     clk_i, rst_n_i  clock, asynchronous active-low reset
//     start           request a conversion (honoured only while idle)
//     value           binary value captured on an accepted start
//     busy            high while a conversion is in progress
//     done            high for the single DONE cycle; results valid then
//     tens, ones      BCD digits of the captured value
//     ovf             captured value exceeds MAX_DISPLAY
//     cap             the captured value itself
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int BW = 7
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start,
  input  logic [BW-1:0] value,
  output logic          busy,
  output logic          done,
  output logic [3:0]    tens,
  output logic [3:0]    ones,
  output logic          ovf,
  output logic [BW-1:0] cap
);

  localparam logic [2:0] LAST_ITER = 3'(BW - 1);

  state_t        state_q;
  logic [BW-1:0] bin_q;
  logic [BW-1:0] cap_q;
  logic [9:0]    bcd_q;    // {hundreds[1:0], tens[3:0], ones[3:0]}
  logic [9:0]    bcd_adj;
  logic [2:0]    iter_q;

  // Hundreds never exceeds 1 for BW<=7, so only tens/ones need the +3 fix.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      bin_q   <= '0;
      cap_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= value;
            cap_q   <= value;
            bcd_q   <= '0;
            iter_q  <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          iter_q <= iter_q + 3'd1;
          if (iter_q == LAST_ITER) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];
  assign ovf  = (32'(cap_q) > MAX_DISPLAY);
  assign cap  = cap_q;

endmodule

// File: rtl/score_display_driver.sv
// score_display_driver
//   Converts the scoreboard count to two BCD digits and multiplexes them
//   onto a shared active-high 7-segment bus. Values above 99 show "--".
//   Ports:
//     clk_i      system clock
//     rst_n_i    asynchronous active-low reset
//     value_i    binary count to display
//     busy_o     conversion in progress
//     seg_o      segments, bit0=a .. bit6=g
//     dig_sel_o  one-hot digit enable, bit0=ones, bit1=tens
//   Build option:
//     SCORE_DISPLAY_LEADING_ZERO_BLANK_EN  blank a leading tens zero
module score_display_driver
  import score_display_pkg::*;
#(
  parameter int BW         = 7,
  parameter int REFRESH_BW = 10
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [BW-1:0] value_i,
  output logic          busy_o,
  output logic [6:0]    seg_o,
  output logic [1:0]    dig_sel_o
);

  logic [BW-1:0]         last_q;
  logic [3:0]            tens_q;
  logic [3:0]            ones_q;
  logic                  ovf_q;
  logic [REFRESH_BW-1:0] refresh_q;

  logic          conv_done;
  logic [3:0]    conv_tens;
  logic [3:0]    conv_ones;
  logic          conv_ovf;
  logic [BW-1:0] conv_cap;
  logic          tens_phase;
  logic [6:0]    digit_seg;

  bin2bcd_seq #(
    .BW(BW)
  ) u_conv (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start   (value_i != last_q),
    .value   (value_i),
    .busy    (busy_o),
    .done    (conv_done),
    .tens    (conv_tens),
    .ones    (conv_ones),
    .ovf     (conv_ovf),
    .cap     (conv_cap)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
      ovf_q  <= 1'b0;
    end else if (conv_done) begin
      last_q <= conv_cap;
      tens_q <= conv_tens;
      ones_q <= conv_ones;
      ovf_q  <= conv_ovf;
    end
  end

  assign tens_phase = refresh_q[REFRESH_BW-1];

  always_comb begin
    digit_seg = seg_decode(ones_q);
    if (ovf_q) begin
      digit_seg = SEG_DASH;
    end else if (tens_phase) begin
`ifdef SCORE_DISPLAY_LEADING_ZERO_BLANK_EN
      digit_seg = (tens_q == 4'd0) ? 7'h00 : seg_decode(tens_q);
`else
      digit_seg = seg_decode(tens_q);
`endif
    end
  end

  // Segments and enable are registered together so they switch on one edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      refresh_q <= '0;
      seg_o     <= '0;
      dig_sel_o <= '0;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      seg_o     <= digit_seg;
      dig_sel_o <= tens_phase ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
module tb_score_display_driver;

  localparam int BW    = 7;
  localparam int RBW   = 4;
  localparam int HALF  = 1 << (RBW - 1);
  localparam int LAT   = BW + 1;
`ifdef SCORE_DISPLAY_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [6:0] SEGS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam int TENS0 = BLANK ? 'h00 : 'h3F;
  localparam int CORNER [6] = '{0, 9, 10, 99, 100, 127};

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [BW-1:0] value_i = '0;
  logic          busy_o;
  logic [6:0]    seg_o;
  logic [1:0]    dig_sel_o;

  int n_total = 0;
  int n_pass  = 0;

  score_display_driver #(
    .BW(BW),
    .REFRESH_BW(RBW)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .value_i  (value_i),
    .busy_o   (busy_o),
    .seg_o    (seg_o),
    .dig_sel_o(dig_sel_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: a conversion accepted when idle lands on the display
  // LAT edges later; outputs show the previous cycle's display and phase.
  int         m_cnt  = 0;
  int         m_rem  = 0;
  int         m_last = 0;
  int         m_pend = 0;
  int         m_disp = 0;
  logic [6:0] e_seg  = '0;
  logic [1:0] e_sel  = '0;
  logic       e_busy = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0; m_rem = 0; m_last = 0; m_pend = 0; m_disp = 0;
      e_seg = '0; e_sel = '0; e_busy = 1'b0;
    end else begin
      bit tens;
      tens = (m_cnt % (2 * HALF)) >= HALF;
      if (m_disp > 99)                     e_seg = 7'h40;
      else if (tens && BLANK && m_disp < 10) e_seg = 7'h00;
      else if (tens)                       e_seg = SEGS[m_disp / 10];
      else                                 e_seg = SEGS[m_disp % 10];
      e_sel = tens ? 2'b10 : 2'b01;
      if (m_rem == 0) begin
        if (int'(value_i) != m_last) begin
          m_pend = int'(value_i);
          m_rem  = LAT;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_disp = m_pend;
          m_last = m_pend;
        end
      end
      e_busy = (m_rem != 0);
      m_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy", int'(busy_o), int'(e_busy));
    chk("seg", int'(seg_o), int'(e_seg));
    chk("dig_sel", int'(dig_sel_o), int'(e_sel));
  end

  task automatic wait_sel(input logic [1:0] s);
    int k;
    k = 0;
    while (dig_sel_o != s && k < 4 * HALF) begin
      @(negedge clk);
      k++;
    end
    if (dig_sel_o != s) begin
      n_total++;
      $display("FAIL wait_sel: dig_sel_o 'h%0h never reached 'h%0h", dig_sel_o, s);
    end
  endtask

  task automatic show(input int v, input int ones_exp, input int tens_exp);
    value_i = BW'(v);
    repeat (LAT + 4) @(negedge clk);
    wait_sel(2'b01);
    chk($sformatf("ones_%0d", v), int'(seg_o), ones_exp);
    wait_sel(2'b10);
    chk($sformatf("tens_%0d", v), int'(seg_o), tens_exp);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_seg", int'(seg_o), 0);
    chk("rst_sel", int'(dig_sel_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wait_sel(2'b01);
    chk("init_ones", int'(seg_o), 'h3F);
    wait_sel(2'b10);
    chk("init_tens", int'(seg_o), TENS0);

    show(42, 'h5B, 'h66);
    show(99, 'h6F, 'h6F);
    show(100, 'h40, 'h40);
    show(127, 'h40, 'h40);
    show(5, 'h6D, TENS0);
    show(7, 'h07, TENS0);

    // Change during a conversion: second capture waits for the first IDLE cycle.
    value_i = 7'd42;
    repeat (3) @(negedge clk);
    value_i = 7'd7;
    repeat (LAT + 1 - 3) @(negedge clk);
    chk("idle_gap_busy", int'(busy_o), 0);
    @(negedge clk);
    chk("second_capture_busy", int'(busy_o), 1);
    repeat (LAT + 4) @(negedge clk);
    wait_sel(2'b01);
    chk("after_ones_7", int'(seg_o), 'h07);

    // Reset mid-conversion clears outputs without waiting for a clock edge.
    value_i = 7'd55;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_seg", int'(seg_o), 0);
    chk("abort_sel", int'(dig_sel_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    @(negedge clk);
    value_i = 7'd0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 250; i++) begin
      int v;
      int h;
      if ($urandom_range(0, 3) == 0) v = CORNER[$urandom_range(0, 5)];
      else v = int'($urandom_range(0, 127));
      value_i = BW'(v);
      h = int'($urandom_range(1, 20));
      repeat (h) @(negedge clk);
    end
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
- Display-side consumer of the scoreboard count value. Converts a BW-bit binary value to two BCD digits with a sequential double-dabble engine.
- Time-multiplexes the two digits onto one shared 7-segment bus with one-hot digit enables.
- Sits between the counter's value output and the board's two-digit common-segment display.
- Values above 99 cannot be displayed and show as "--".

Parameters:
- BW, 7, width of value_i; legal range 4..7.
- REFRESH_BW, 10, refresh counter width; each digit is lit for 2^(REFRESH_BW-1) cycles.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  reset, asynchronous, active-low
- value_i  input  BW  binary count to display, 0..2^BW-1
- busy_o  output  1  high while a conversion is in progress
- seg_o  output  7  segments, active-high; bit0=a .. bit6=g
- dig_sel_o  output  2  one-hot digit enable; bit0=ones, bit1=tens

Behaviour:
- One clock; reset is asynchronous and active-low. All state is in flops reset by rst_n_i.
- Reset values:
  - state=IDLE, last_q=0, tens_q=0, ones_q=0, ovf_q=0, refresh counter=0.
  - busy_o=0, seg_o=7'h00, dig_sel_o=2'b00.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If value_i != last_q: capture value_i into the shift register, clear the BCD scratch (10 bits: hundreds[1:0], tens[3:0], ones[3:0]), clear iter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each edge: add 3 to every BCD nibble that is >=5, then shift {bcd, bin} left by 1; iter++.
  - After BW edges, go to DONE.
- DONE (single edge):
  - tens_q/ones_q <= scratch digits; ovf_q <= (captured value > 99); last_q <= captured value.
  - Go to IDLE.
- busy_o = (state != IDLE).
- Latency: capture edge N → display registers updated at edge N+BW+1 (8 cycles for BW=7).
- value_i changes while busy_o=1 are ignored; the new value is compared on the first IDLE cycle and converted then.
- Back-to-back changes give one conversion per BW+2 cycles. Intermediate values may be skipped; the last stable value is always displayed.
- Refresh counter:
  - Free-running, REFRESH_BW bits, wraps silently.
  - MSB=0 selects the ones digit; MSB=1 selects the tens digit.
- Outputs:
  - seg_o and dig_sel_o are registered together and change on the same edge, one cycle after the select bit changes.
  - No cycle ever drives two digit enables.
- Segment codes:
  - 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Dash = 40; used for both digits when ovf_q=1.
- Reset asserted mid-conversion aborts the conversion and returns all outputs to reset values immediately.

Optional Feature:
- Macro: SCORE_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined: when tens_q=0 and ovf_q=0, the tens phase drives seg_o=7'h00. dig_sel_o still cycles normally.
- Undefined: the tens digit 0 displays as 3F.

Decomposition:
- Package score_display_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - the segment constants SEG_DIGIT[0:9] and SEG_DASH;
  - MAX_DISPLAY=99.
- One sub-module: bin2bcd_seq, containing the FSM, double-dabble datapath and busy.
  - Interface: start/value in; done/tens/ones/ovf out.
- Top level holds last_q, the display registers, the refresh counter and the segment decode.

Test Plan (REFRESH_BW=4 in simulation):
1. rst_n_i low for 3 cycles, released → seg_o=00 and dig_sel_o=00 asynchronously; after release the display shows "00" (ones 3F / tens 3F), and busy_o never rises with value_i=0.
2. value_i 0→42 at edge N → busy_o high for edges N+1..N+8. From N+8: ones phase seg_o=5B with dig_sel_o=01; tens phase seg_o=66 with dig_sel_o=10.
3. value_i=99 → both digits 6F. Then value_i=100 → both digits 40; value_i=127 → both digits 40. Then 5 → ones 6D, tens 3F.
4. value_i=42, then 7 three cycles after capture → display shows 42 first. A second conversion starts on the first IDLE cycle, and "07" appears 8 cycles after that capture.
5. Refresh: dig_sel_o alternates 01 for 8 cycles, 10 for 8 cycles, continuously. Never 11; never 00 after reset.
6. Macro defined, value_i=7 → tens phase seg_o=00, ones 07. Macro undefined → tens 3F.
